// File: rtl/skid_buffer_pipe.sv
// rtl/skid_buffer_pipe.sv - two-entry registered valid/ready skid buffer
// Optional sticky upstream protocol checker: SKID_BUFFER_PIPE_PROTOCOL_CHECK_EN
module skid_buffer_pipe #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ready_out,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
`ifdef SKID_BUFFER_PIPE_PROTOCOL_CHECK_EN
  output logic                  protocol_err,
`endif
  input  logic                  ready_in
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  ready_q, valid_q;
  logic                  acc, fire;

  assign acc  = valid_in & ready_q;
  assign fire = valid_q & ready_in;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          out_d   = data_in;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (acc && fire) begin
          out_d = data_in;
        end else if (acc) begin
          skid_d  = data_in;
          state_d = ST_FULL;
        end else if (fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // ready_out is low here, so the only move is draining the skid entry
        if (fire) begin
          out_d   = skid_q;
          state_d = ST_BUSY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      ready_q <= (state_d != ST_FULL);
      valid_q <= (state_d != ST_EMPTY);
    end
  end

  assign ready_out = ready_q;
  assign valid_out = valid_q;
  assign data_out  = out_q;

`ifdef SKID_BUFFER_PIPE_PROTOCOL_CHECK_EN
  logic                  stall_q;
  logic [DATA_WIDTH-1:0] stall_data_q;
  logic                  err_q;

  // A stalled beat must stay offered, unchanged, on the following cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q      <= 1'b0;
      stall_data_q <= '0;
      err_q        <= 1'b0;
    end else begin
      stall_q      <= valid_in & ~ready_q;
      stall_data_q <= data_in;
      if (stall_q && (!valid_in || (data_in != stall_data_q))) begin
        err_q <= 1'b1;
      end
    end
  end

  assign protocol_err = err_q;
`endif

endmodule

// File: tb/tb_skid_buffer_pipe.sv
// tb/tb_skid_buffer_pipe.sv - directed self-checking bench for skid_buffer_pipe
module tb_skid_buffer_pipe;

  logic       clk;
  logic       reset;
  logic       valid_in;
  logic [7:0] data_in;
  logic       ready_out;
  logic       valid_out;
  logic [7:0] data_out;
  logic       ready_in;
`ifdef SKID_BUFFER_PIPE_PROTOCOL_CHECK_EN
  logic       protocol_err;
`endif

  int test_cnt = 0;
  int fail_cnt = 0;

  skid_buffer_pipe #(.DATA_WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .data_out  (data_out),
`ifdef SKID_BUFFER_PIPE_PROTOCOL_CHECK_EN
    .protocol_err (protocol_err),
`endif
    .ready_in  (ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    test_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic r, input logic [7:0] d);
    check_eq({tag, ".valid"}, {31'd0, valid_out}, {31'd0, v});
    check_eq({tag, ".ready"}, {31'd0, ready_out}, {31'd0, r});
    check_eq({tag, ".data"},  {24'd0, data_out},  {24'd0, d});
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b1; data_in = 8'h5A; ready_in = 1'b0;
    tick();
    check_out("rst1", 1'b0, 1'b0, 8'h00);
    tick();
    check_out("rst2", 1'b0, 1'b0, 8'h00);
    reset = 1'b0; valid_in = 1'b0;
    tick();
    check_out("rel", 1'b0, 1'b1, 8'h00);

    // Streaming at full rate
    ready_in = 1'b1; valid_in = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      data_in = 8'(i);
      tick();
      check_out($sformatf("stream%0d", i), 1'b1, 1'b1, 8'(i));
    end
    valid_in = 1'b0;
    tick();
    check_out("stream_idle", 1'b0, 1'b1, 8'h03);

    // Stall and skid
    valid_in = 1'b1; data_in = 8'h10;
    tick();
    check_out("skid_10", 1'b1, 1'b1, 8'h10);
    ready_in = 1'b0; data_in = 8'h11;
    tick();
    check_out("skid_full", 1'b1, 1'b0, 8'h10);
    data_in = 8'h12;
    tick();
    check_out("skid_hold1", 1'b1, 1'b0, 8'h10);
    tick();
    check_out("skid_hold2", 1'b1, 1'b0, 8'h10);
    ready_in = 1'b1;
    tick();
    check_out("skid_11", 1'b1, 1'b1, 8'h11);
    tick();
    check_out("skid_12", 1'b1, 1'b1, 8'h12);
    valid_in = 1'b0;
    tick();
    check_out("skid_empty", 1'b0, 1'b1, 8'h12);

    // Fill then drain with no new input
    ready_in = 1'b0; valid_in = 1'b1; data_in = 8'hA0;
    tick();
    data_in = 8'hA1;
    tick();
    check_out("drain_full", 1'b1, 1'b0, 8'hA0);
    valid_in = 1'b0; ready_in = 1'b1;
    tick();
    check_out("drain_1", 1'b1, 1'b1, 8'hA1);
    tick();
    check_out("drain_2", 1'b0, 1'b1, 8'hA1);

    // Mid-stream reset discards both held beats
    ready_in = 1'b0; valid_in = 1'b1; data_in = 8'h20;
    tick();
    data_in = 8'h21;
    tick();
    check_out("mrst_full", 1'b1, 1'b0, 8'h20);
    reset = 1'b1; valid_in = 1'b0;
    tick();
    check_out("mrst_rst", 1'b0, 1'b0, 8'h00);
    reset = 1'b0; ready_in = 1'b1;
    tick();
    check_out("mrst_rel", 1'b0, 1'b1, 8'h00);
    tick();
    check_out("mrst_idle", 1'b0, 1'b1, 8'h00);

`ifdef SKID_BUFFER_PIPE_PROTOCOL_CHECK_EN
    check_eq("perr_clear", {31'd0, protocol_err}, 32'd0);
    ready_in = 1'b0; valid_in = 1'b1; data_in = 8'h30;
    tick();
    tick();
    tick();
    check_eq("perr_stable", {31'd0, protocol_err}, 32'd0);
    data_in = 8'h31;
    tick();
    check_eq("perr_set", {31'd0, protocol_err}, 32'd1);
    valid_in = 1'b0; ready_in = 1'b1;
    tick();
    tick();
    check_eq("perr_sticky", {31'd0, protocol_err}, 32'd1);
    reset = 1'b1;
    tick();
    check_eq("perr_rst", {31'd0, protocol_err}, 32'd0);
    reset = 1'b0;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
